huffman_freq_counter: RTL and testbench
=======================================

Name: huffman_freq_counter

Overview:
Upstream stage of the Huffman encoder. It accepts a stream of 4-bit symbols and builds a 16-bin occurrence histogram. After the last symbol it emits the (symbol, frequency) pairs in ascending symbol order over a valid/ready handshake. The Huffman tree/length builder consumes these pairs and produces its code lengths and done.

Parameters:
SYM_W, 4, symbol width; number of bins NSYM = 2**SYM_W
CNT_W, 8, width of each per-symbol frequency counter
SKIP_ZERO, 1, 1 = do not emit bins with count 0; 0 = emit all NSYM bins

Ports:
CLK  input  1  clock; all logic on rising edge
nRST  input  1  synchronous reset, active-low
start  input  1  begin a new histogram (honoured only in IDLE)
sym_valid  input  1  sym carries a symbol this cycle
sym  input  SYM_W  input symbol
sym_last  input  1  qualifies the final symbol of the block (with sym_valid)
sym_ready  output  1  high exactly when state is COUNT
busy  output  1  high in COUNT and DUMP
out_valid  output  1  out_sym/out_freq hold a valid pair
out_ready  input  1  consumer accepts the pair
out_sym  output  SYM_W  symbol index of the current pair
out_freq  output  CNT_W  count for out_sym
out_last  output  1  current pair is the final emitted pair
total_count  output  CNT_W+SYM_W  symbols counted in the block, saturating; held until next start
done  output  1  one-cycle pulse after the final pair transfers

Behaviour:
- Reset: nRST low at a rising edge forces state IDLE. All bins = 0, total_count = 0, index = 0, done = 0. out_valid, sym_ready, busy and out_last are all 0. Reset applies from any state, including mid-COUNT and mid-DUMP. Any partial histogram is discarded.
- States: IDLE, COUNT, DUMP, DONE.
- IDLE:
  - start = 1: clear all bins and total_count, go to COUNT.
  - Symbols presented in IDLE are ignored.
- COUNT:
  - Each cycle with sym_valid = 1: bin[sym] += 1 and total_count += 1.
  - Both saturate at all-ones; no wrap.
  - sym_valid with sym_last: that symbol is counted, then index := 0 and state goes to DUMP on the next cycle.
  - start in COUNT, DUMP or DONE is ignored.
- DUMP:
  - out_sym = index and out_freq = bin[index], both driven directly from registers (no extra latency).
  - SKIP_ZERO = 1 and bin[index] == 0: out_valid = 0 and index advances by 1 this cycle (one skip cycle per empty bin).
  - Otherwise out_valid = 1. out_sym and out_freq stay stable until a cycle with out_valid && out_ready; then index advances.
  - out_last = out_valid && (SKIP_ZERO ? no nonzero bin above index : index == NSYM-1).
  - A transfer with out_last = 1 moves to DONE.
  - At least one symbol is always counted, so at least one pair is always emitted.
- DONE: done = 1 for exactly one cycle, then IDLE.
  - Bins and total_count hold their values until the next start.
- out_ready is ignored whenever out_valid = 0.

Test Plan:
1. Reset, then hold nRST low for 3 cycles -> every output 0, state IDLE. Symbols sent while in IDLE leave total_count at 0.
2. start, then symbols 1,2,2,3,3,3 back-to-back with sym_last on the final 3, out_ready = 1 -> pairs (1,1), (2,2), (3,3), with out_last only on (3,3). total_count = 6; done pulses once on the cycle after (3,3) transfers.
3. Same stream with out_ready low for 5 cycles while (2,2) is presented -> out_valid stays 1 and out_sym = 2, out_freq = 2 are stable throughout. Transfer occurs on the first cycle out_ready = 1, with no lost or duplicated pairs.
4. CNT_W = 8: 300 symbols of value 5, then one 9 with sym_last -> pairs (5,255), (9,1); total_count = 301.
5. SKIP_ZERO = 0: stream of symbols 0 and 15 only -> exactly 16 pairs; bins 1..14 emitted with freq 0; out_last on out_sym = 15.
6. Assert start during COUNT -> counts are not cleared. Assert nRST low during DUMP -> next cycle out_valid = 0 and busy = 0. A fresh start then yields a histogram with no carry-over.

Source files
------------

// File: rtl/huffman_freq_counter.sv
// huffman_freq_counter
// Front end of the Huffman encoder. It builds a histogram of a block of
// SYM_W-bit symbols, then emits (symbol, frequency) pairs in ascending
// symbol order over a valid/ready handshake.
//
// Ports
//   CLK, nRST     clock (rising edge) and synchronous active-low reset
//   start         begin a new histogram (honoured only in IDLE)
//   sym_valid     sym carries a symbol this cycle
//   sym           input symbol
//   sym_last      marks the final symbol of the block
//   sym_ready     high while counting
//   busy          high while counting or dumping
//   out_valid     out_sym/out_freq hold a valid pair
//   out_ready     consumer accepts the pair
//   out_sym       symbol index of the current pair
//   out_freq      frequency of out_sym
//   out_last      current pair is the final pair emitted
//   total_count   symbols counted in the block (saturating)
//   done          one-cycle pulse after the final pair transfers
module huffman_freq_counter #(
  parameter int SYM_W     = 4,
  parameter int CNT_W     = 8,
  parameter int SKIP_ZERO = 1
) (
  input  logic                     CLK,
  input  logic                     nRST,
  input  logic                     start,
  input  logic                     sym_valid,
  input  logic [SYM_W-1:0]         sym,
  input  logic                     sym_last,
  output logic                     sym_ready,
  output logic                     busy,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [SYM_W-1:0]         out_sym,
  output logic [CNT_W-1:0]         out_freq,
  output logic                     out_last,
  output logic [CNT_W+SYM_W-1:0]   total_count,
  output logic                     done
);

  localparam int NSYM = 2**SYM_W;

  typedef enum logic [1:0] {S_IDLE, S_COUNT, S_DUMP, S_DONE} state_t;

  state_t                   r_state;
  state_t                   w_next;
  logic [CNT_W-1:0]         r_bin [NSYM];
  logic [CNT_W+SYM_W-1:0]   r_total;
  logic [SYM_W-1:0]         r_idx;

  logic w_any_above;
  logic w_skip;
  logic w_valid;
  logic w_last;
  logic w_xfer;

  // Any nonzero bin strictly above the current index; decides out_last
  // when empty bins are suppressed.
  always_comb begin
    w_any_above = 1'b0;
    for (int unsigned j = 0; j < NSYM; j++) begin
      if ((SYM_W'(j) > r_idx) && (r_bin[SYM_W'(j)] != '0)) begin
        w_any_above = 1'b1;
      end
    end
  end

  always_comb begin
    w_skip  = (r_state == S_DUMP) && (SKIP_ZERO != 0) && (r_bin[r_idx] == '0);
    w_valid = (r_state == S_DUMP) && !w_skip;
    w_last  = w_valid && ((SKIP_ZERO != 0) ? !w_any_above : (r_idx == '1));
    w_xfer  = w_valid && out_ready;
  end

  always_comb begin
    sym_ready   = (r_state == S_COUNT);
    busy        = (r_state == S_COUNT) || (r_state == S_DUMP);
    out_valid   = w_valid;
    out_last    = w_last;
    out_sym     = r_idx;
    out_freq    = r_bin[r_idx];
    total_count = r_total;
    done        = (r_state == S_DONE);
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next = S_COUNT;
      S_COUNT: if (sym_valid && sym_last) w_next = S_DUMP;
      S_DUMP:  if (w_xfer && w_last) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      for (int unsigned j = 0; j < NSYM; j++) begin
        r_bin[SYM_W'(j)] <= '0;
      end
      r_total <= '0;
      r_idx   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            for (int unsigned j = 0; j < NSYM; j++) begin
              r_bin[SYM_W'(j)] <= '0;
            end
            r_total <= '0;
          end
        end
        S_COUNT: begin
          if (sym_valid) begin
            if (r_bin[sym] != '1) r_bin[sym] <= r_bin[sym] + 1'b1;
            if (r_total != '1)    r_total    <= r_total + 1'b1;
            if (sym_last)         r_idx      <= '0;
          end
        end
        S_DUMP: begin
          // Index holds on the final transfer so the last pair stays visible.
          if (w_skip || (w_xfer && !w_last)) r_idx <= r_idx + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_huffman_freq_counter.sv
module tb_huffman_freq_counter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       nrst, start, sym_valid, sym_last, out_ready;
  logic [3:0] sym;

  // Index 0: SKIP_ZERO=1 instance, index 1: SKIP_ZERO=0 instance.
  logic       ov [2];
  logic       ol [2];
  logic       sr [2];
  logic       bz [2];
  logic       dn [2];
  logic [3:0] osym [2];
  logic [7:0] ofreq [2];
  logic [11:0] tot [2];

  huffman_freq_counter #(.SYM_W(4), .CNT_W(8), .SKIP_ZERO(1)) u_skip (
    .CLK(clk), .nRST(nrst), .start(start), .sym_valid(sym_valid), .sym(sym),
    .sym_last(sym_last), .sym_ready(sr[0]), .busy(bz[0]), .out_valid(ov[0]),
    .out_ready(out_ready), .out_sym(osym[0]), .out_freq(ofreq[0]),
    .out_last(ol[0]), .total_count(tot[0]), .done(dn[0])
  );

  huffman_freq_counter #(.SYM_W(4), .CNT_W(8), .SKIP_ZERO(0)) u_all (
    .CLK(clk), .nRST(nrst), .start(start), .sym_valid(sym_valid), .sym(sym),
    .sym_last(sym_last), .sym_ready(sr[1]), .busy(bz[1]), .out_valid(ov[1]),
    .out_ready(out_ready), .out_sym(osym[1]), .out_freq(ofreq[1]),
    .out_last(ol[1]), .total_count(tot[1]), .done(dn[1])
  );

  int n_checks = 0;
  int n_fail   = 0;

  function automatic void check(string name, int act, int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endfunction

  typedef struct packed {
    logic [3:0] s;
    logic [7:0] f;
    logic       l;
  } pair_t;

  pair_t      pq0[$];
  pair_t      pq1[$];
  int         done_cnt [2];
  bit         exp_done [2];
  bit         stalled [2];
  logic [3:0] st_sym [2];
  logic [7:0] st_freq [2];
  int         ready_mode = 0;
  int         stall_cnt  = 0;

  // Observes one instance on the falling edge: records transfers, checks
  // that a stalled pair is held, and that done follows the last transfer.
  task automatic mon(input bit k, input logic v, input logic l, input logic d,
                     input logic [3:0] s, input logic [7:0] f);
    pair_t p;
    if (exp_done[k]) begin
      check($sformatf("done_after_last[%0d]", k), int'(d), 1);
      exp_done[k] = 1'b0;
    end
    if (d) done_cnt[k]++;
    if (stalled[k]) begin
      check($sformatf("hold_valid[%0d]", k), int'(v), 1);
      check($sformatf("hold_sym[%0d]", k), int'(s), int'(st_sym[k]));
      check($sformatf("hold_freq[%0d]", k), int'(f), int'(st_freq[k]));
    end
    stalled[k] = nrst && v && !out_ready;
    st_sym[k]  = s;
    st_freq[k] = f;
    if (nrst && v && out_ready) begin
      p.s = s;
      p.f = f;
      p.l = l;
      if (k == 1'b0) pq0.push_back(p);
      else           pq1.push_back(p);
      if (l) exp_done[k] = 1'b1;
    end
    if (!nrst) exp_done[k] = 1'b0;
  endtask

  initial begin
    forever begin
      @(negedge clk);
      mon(1'b0, ov[0], ol[0], dn[0], osym[0], ofreq[0]);
      mon(1'b1, ov[1], ol[1], dn[1], osym[1], ofreq[1]);
    end
  end

  // out_ready driver: 0 = always ready, 1 = random, 2 = stall 5 cycles on sym 2.
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        1: out_ready = 1'($urandom_range(0, 1));
        2: begin
          if (ov[0] && osym[0] == 4'd2 && stall_cnt < 5) begin
            out_ready = 1'b0;
            stall_cnt++;
          end else begin
            out_ready = 1'b1;
          end
        end
        default: out_ready = 1'b1;
      endcase
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic compare_q(input string tag, input pair_t got[$], input pair_t exp[$]);
    int n;
    check($sformatf("%s.npairs", tag), got.size(), exp.size());
    n = (got.size() < exp.size()) ? got.size() : exp.size();
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s[%0d].sym", tag, i), int'(got[i].s), int'(exp[i].s));
      check($sformatf("%s[%0d].freq", tag, i), int'(got[i].f), int'(exp[i].f));
      check($sformatf("%s[%0d].last", tag, i), int'(got[i].l), int'(exp[i].l));
    end
  endtask

  // Runs one block through both instances and compares against a plain
  // histogram of the symbol list. start_mid_at re-asserts start on that symbol.
  task automatic run_block(input logic [3:0] syms[$], input int mode, input int start_mid_at);
    int    h [16];
    int    tot_e;
    bit    got;
    pair_t e;
    pair_t ea[$];
    pair_t eb[$];
    logic [3:0] bi;
    pq0.delete();
    pq1.delete();
    done_cnt[0] = 0;
    done_cnt[1] = 0;
    ready_mode  = mode;
    stall_cnt   = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("sym_ready_after_start[0]", int'(sr[0]), 1);
    check("sym_ready_after_start[1]", int'(sr[1]), 1);
    check("busy_after_start", int'(bz[0]), 1);
    foreach (syms[i]) begin
      sym_valid = 1'b1;
      sym       = syms[i];
      sym_last  = (i == syms.size() - 1);
      start     = (i == start_mid_at);
      tick();
    end
    sym_valid = 1'b0;
    sym_last  = 1'b0;
    start     = 1'b0;
    got = 1'b0;
    for (int c = 0; c < 3000 && !got; c++) begin
      tick();
      got = (done_cnt[0] > 0) && (done_cnt[1] > 0);
    end
    check("done_seen", int'(got), 1);
    repeat (3) tick();
    check("done_pulses[0]", done_cnt[0], 1);
    check("done_pulses[1]", done_cnt[1], 1);
    check("busy_end[0]", int'(bz[0]), 0);
    check("busy_end[1]", int'(bz[1]), 0);

    for (int b = 0; b < 16; b++) begin
      bi = 4'(b);
      h[bi] = 0;
    end
    tot_e = 0;
    foreach (syms[i]) begin
      if (h[syms[i]] < 255) h[syms[i]]++;
      if (tot_e < 4095) tot_e++;
    end
    check("total[0]", int'(tot[0]), tot_e);
    check("total[1]", int'(tot[1]), tot_e);
    for (int b = 0; b < 16; b++) begin
      bi  = 4'(b);
      e.s = bi;
      e.f = 8'(h[bi]);
      e.l = 1'b0;
      if (h[bi] != 0) ea.push_back(e);
      eb.push_back(e);
    end
    if (ea.size() > 0) ea[ea.size()-1].l = 1'b1;
    eb[15].l = 1'b1;
    compare_q("skip", pq0, ea);
    compare_q("all", pq1, eb);
  endtask

  task automatic check_reset_outputs(input string tag);
    for (int k = 0; k < 2; k++) begin
      check($sformatf("%s.out_valid[%0d]", tag, k), int'(ov[1'(k)]), 0);
      check($sformatf("%s.out_last[%0d]", tag, k), int'(ol[1'(k)]), 0);
      check($sformatf("%s.sym_ready[%0d]", tag, k), int'(sr[1'(k)]), 0);
      check($sformatf("%s.busy[%0d]", tag, k), int'(bz[1'(k)]), 0);
      check($sformatf("%s.done[%0d]", tag, k), int'(dn[1'(k)]), 0);
      check($sformatf("%s.total[%0d]", tag, k), int'(tot[1'(k)]), 0);
      check($sformatf("%s.out_sym[%0d]", tag, k), int'(osym[1'(k)]), 0);
      check($sformatf("%s.out_freq[%0d]", tag, k), int'(ofreq[1'(k)]), 0);
    end
  endtask

  typedef struct packed {
    logic [31:0] syms;       // symbol i in bits [4*i +: 4]
    logic [3:0]  n;
    logic [11:0] exp_total;
    logic [4:0]  exp_npairs; // pairs emitted with empty bins skipped
  } vec_t;

  vec_t tbl [4];

  initial begin
    logic [3:0] q[$];
    bit         seen;

    tbl[0] = '{32'h00333221, 4'd6, 12'd6, 5'd3};
    tbl[1] = '{32'h00000000, 4'd1, 12'd1, 5'd1};
    tbl[2] = '{32'h000000FF, 4'd2, 12'd2, 5'd1};
    tbl[3] = '{32'h000277F0, 4'd5, 12'd5, 5'd4};

    nrst = 1'b0; start = 1'b0; sym_valid = 1'b0; sym_last = 1'b0; sym = '0;

    // Reset held low, then symbols offered in IDLE must be ignored.
    repeat (3) tick();
    check_reset_outputs("reset");
    nrst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      sym_valid = 1'b1;
      sym       = 4'(i + 3);
      tick();
    end
    sym_valid = 1'b0;
    tick();
    check("idle_ignore.total[0]", int'(tot[0]), 0);
    check("idle_ignore.total[1]", int'(tot[1]), 0);
    check("idle_ignore.sym_ready", int'(sr[0]), 0);

    // Table-driven blocks.
    for (int t = 0; t < 4; t++) begin
      q.delete();
      for (int i = 0; i < int'(tbl[2'(t)].n); i++) q.push_back(tbl[2'(t)].syms[4*i +: 4]);
      run_block(q, 0, -1);
      check($sformatf("tbl%0d.total", t), int'(tot[0]), int'(tbl[2'(t)].exp_total));
      check($sformatf("tbl%0d.npairs", t), pq0.size(), int'(tbl[2'(t)].exp_npairs));
    end

    // Consumer stalls 5 cycles on pair (2,2).
    q = '{4'd1, 4'd2, 4'd2, 4'd3, 4'd3, 4'd3};
    run_block(q, 2, -1);
    check("stall_cycles", stall_cnt, 5);

    // Per-bin saturation: 300 x 5 then a final 9.
    q.delete();
    repeat (300) q.push_back(4'd5);
    q.push_back(4'd9);
    run_block(q, 1, -1);
    if (pq0.size() > 0) check("sat.freq5", int'(pq0[0].f), 255);
    check("sat.total", int'(tot[0]), 301);

    // Only bins 0 and 15 populated: full dump emits all 16.
    q = '{4'd0, 4'd15, 4'd15, 4'd0, 4'd15};
    run_block(q, 0, -1);
    check("all.count16", pq1.size(), 16);

    // start during COUNT is ignored.
    q.delete();
    for (int i = 0; i < 10; i++) q.push_back(4'($urandom_range(0, 15)));
    run_block(q, 1, 3);

    // Reset during DUMP, then a fresh block with no carry-over.
    ready_mode = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    q = '{4'd4, 4'd4, 4'd6};
    foreach (q[i]) begin
      sym_valid = 1'b1;
      sym       = q[i];
      sym_last  = (i == q.size() - 1);
      tick();
    end
    sym_valid = 1'b0;
    sym_last  = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 100 && !seen; c++) begin
      if (ov[0]) seen = 1'b1;
      else       tick();
    end
    check("abort.dump_seen", int'(seen), 1);
    nrst = 1'b0;
    tick();
    check("abort.out_valid[0]", int'(ov[0]), 0);
    check("abort.out_valid[1]", int'(ov[1]), 0);
    check("abort.busy[0]", int'(bz[0]), 0);
    check("abort.busy[1]", int'(bz[1]), 0);
    nrst = 1'b1;
    tick();
    q = '{4'd7, 4'd8, 4'd8};
    run_block(q, 0, -1);

    // Random blocks with random back-pressure.
    for (int r = 0; r < 6; r++) begin
      q.delete();
      repeat ($urandom_range(1, 40)) q.push_back(4'($urandom_range(0, 15)));
      run_block(q, 1, -1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
